round_sequencer: RTL
====================

Name: round_sequencer

Overview:
- Parametrised successor to the fixed 16-round counter in the cipher datapath.
- Sequences a run-time programmable number of cipher rounds, either ascending (encrypt) or descending (decrypt).
- Provides a start/done handshake, per-round valid and first/last round indicators, stall support, and synchronous abort.
- Sits between the cipher top-level controller and the key-schedule/round-datapath.

Parameters:
NUM_CNT_BITS, 5, width of round index and round-count bus; max rounds = 2^NUM_CNT_BITS - 1.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous active-high reset.
start  input  1  request to begin a round sequence; sampled in IDLE only.
rounds_val  input  NUM_CNT_BITS  number of rounds N; sampled with start.
ed_sel  input  1  0 = encrypt (count up 1..N), 1 = decrypt (count down N..1); sampled with start.
count_enable  input  1  advance to next round when high in RUN; low = stall.
clear  input  1  synchronous abort to IDLE.
count_out  output  NUM_CNT_BITS  current round index.
round_valid  output  1  high throughout RUN.
first_round  output  1  RUN and count_out equals starting index.
last_round  output  1  RUN and count_out equals final index.
busy  output  1  high in RUN or DONE.
done  output  1  one-cycle pulse on completion.
cfg_err  output  1  one-cycle pulse when start is presented with rounds_val = 0.

Behaviour:
- Reset (async, rst=1): state IDLE; count_out=0; latched limit=0; latched mode=0; done=0; cfg_err=0. All derived outputs are 0.
- States: IDLE, RUN, DONE. State, count, limit, mode, done and cfg_err are registered. round_valid, first_round, last_round and busy are decoded combinationally from registers.
- IDLE:
  - start=1 and rounds_val!=0: latch limit=rounds_val and mode=ed_sel.
  - Next cycle: state RUN; count_out=1 if mode=0, count_out=limit if mode=1.
  - start=1 and rounds_val=0: remain IDLE; cfg_err=1 for the next cycle; count_out unchanged.
  - count_enable is ignored.
- RUN:
  - count_enable=0: hold all state.
  - count_enable=1, mode=0: if count_out==limit, go to DONE (count_out holds); else count_out+1.
  - count_enable=1, mode=1: if count_out==1, go to DONE (count_out holds); else count_out-1.
  - N=1: first_round and last_round are both high in the single RUN cycle.
- DONE: done=1 for exactly one cycle, then IDLE. count_out holds the final index until the next accepted start or clear.
- start, rounds_val and ed_sel are ignored outside IDLE. Mode and limit cannot change mid-sequence.
- clear has priority over start and count_enable in every state. Next cycle: IDLE, count_out=0, no done pulse.
- start and clear asserted together in IDLE: clear wins; the sequence does not start.
- Latency with count_enable held high: start accepted at edge t gives RUN for edges t+1..t+N, done high for cycle t+N+1, IDLE at t+N+2. Each stall cycle adds one cycle.
- Arithmetic is NUM_CNT_BITS wide. No wrap occurs because termination is detected at the limit or at 1. No value outside 1..limit appears in RUN.
- Reset asserted mid-RUN: immediate return to reset values; no done pulse.

Test Plan:
- Encrypt N=16, ed_sel=0, count_enable=1 -> count_out 1..16 over 16 RUN cycles; first_round at 1, last_round at 16; done pulse exactly 17 cycles after start edge; count_out holds 16 in IDLE.
- Decrypt N=10, ed_sel=1, count_enable toggled 1,0,1,... -> count_out 10,10,9,9,...,1; no index skipped; round_valid high throughout RUN; one done pulse.
- N=1 both modes -> single RUN cycle with count_out=1 and first_round=last_round=1; done on the next cycle.
- start with rounds_val=0 -> cfg_err single pulse, state stays IDLE, busy=0. Start with N=31, ed_sel=1 -> count_out 31..1, no wrap.
- clear at count_out=5 during encrypt N=16, with start asserted the same cycle -> IDLE, count_out=0, no done pulse. A fresh start the following cycle runs normally.
- Async rst pulse mid-RUN, between clock edges -> outputs go to reset values without waiting for a clock edge. A restart with new rounds_val and ed_sel after reset is honoured.

Source files
------------

// File: rtl/round_sequencer_if.sv
// Control/status bundle between the cipher controller (master) and the round sequencer (slave).
// Carries the start/done handshake, round index and per-round status flags.
`timescale 1ns/1ps
interface round_sequencer_if #(
  parameter int unsigned NUM_CNT_BITS = 5
);
  logic                    start;
  logic [NUM_CNT_BITS-1:0] rounds_val;
  logic                    ed_sel;
  logic                    count_enable;
  logic                    clear;
  logic [NUM_CNT_BITS-1:0] count_out;
  logic                    round_valid;
  logic                    first_round;
  logic                    last_round;
  logic                    busy;
  logic                    done;
  logic                    cfg_err;

  modport master (
    output start, rounds_val, ed_sel, count_enable, clear,
    input  count_out, round_valid, first_round, last_round, busy, done, cfg_err
  );

  modport slave (
    input  start, rounds_val, ed_sel, count_enable, clear,
    output count_out, round_valid, first_round, last_round, busy, done, cfg_err
  );
endinterface

// File: rtl/round_sequencer.sv
// Programmable cipher round sequencer: counts 1..N (encrypt) or N..1 (decrypt) with stall,
// synchronous abort, a one-cycle done pulse and a cfg_err pulse for a zero round count.
`timescale 1ns/1ps
module round_sequencer #(
  parameter int unsigned NUM_CNT_BITS = 5
) (
  input logic               clk,
  input logic               rst,
  round_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [NUM_CNT_BITS-1:0] CntOne  = NUM_CNT_BITS'(1);
  localparam logic [NUM_CNT_BITS-1:0] CntZero = '0;

  state_e                  r_state;
  logic [NUM_CNT_BITS-1:0] r_count;
  logic [NUM_CNT_BITS-1:0] r_limit;
  logic                    r_mode;
  logic                    r_done;
  logic                    r_cfg_err;

  logic [NUM_CNT_BITS-1:0] w_start_idx;
  logic [NUM_CNT_BITS-1:0] w_final_idx;
  logic                    w_run;

  assign w_start_idx = r_mode ? r_limit : CntOne;
  assign w_final_idx = r_mode ? CntOne : r_limit;
  assign w_run       = (r_state == StRun);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_count   <= CntZero;
      r_limit   <= CntZero;
      r_mode    <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
      if (bus.clear) begin
        r_state <= StIdle;
        r_count <= CntZero;
      end else begin
        unique case (r_state)
          StIdle: begin
            if (bus.start) begin
              if (bus.rounds_val != CntZero) begin
                r_limit <= bus.rounds_val;
                r_mode  <= bus.ed_sel;
                r_count <= bus.ed_sel ? bus.rounds_val : CntOne;
                r_state <= StRun;
              end else begin
                r_cfg_err <= 1'b1;
              end
            end
          end
          StRun: begin
            // Termination is tested before stepping, so the index never leaves 1..limit.
            if (bus.count_enable) begin
              if (r_count == w_final_idx) begin
                r_state <= StDone;
                r_done  <= 1'b1;
              end else if (r_mode) begin
                r_count <= r_count - CntOne;
              end else begin
                r_count <= r_count + CntOne;
              end
            end
          end
          StDone: begin
            r_state <= StIdle;
          end
          default: begin
            r_state <= StIdle;
          end
        endcase
      end
    end
  end

  assign bus.count_out   = r_count;
  assign bus.round_valid = w_run;
  assign bus.first_round = w_run && (r_count == w_start_idx);
  assign bus.last_round  = w_run && (r_count == w_final_idx);
  assign bus.busy        = w_run || (r_state == StDone);
  assign bus.done        = r_done;
  assign bus.cfg_err     = r_cfg_err;

endmodule
